// File: rtl/quicksort_pkg.sv
// Shared sizes, FSM state encoding, range type and small helpers for the quicksort accelerator.
// Pure declarations: no latency or flow-control behaviour of its own.
package quicksort_pkg;

    localparam int N_ELEMS = 96;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 7;
    localparam int IDX_W   = $clog2(N_ELEMS);

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP,
        PART_INIT,
        PART_SCAN,
        PART_SWAP,
        PART_FINAL,
        DONE
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] lo;
        logic [IDX_W-1:0] hi;
    } range_t;

    function automatic logic [DATA_W-1:0] init_val(input int k);
        return DATA_W'((37 * k + 11) % 256);
    endfunction

    // Bit-count write mask: 8 or more selects the whole byte, 0 writes nothing.
    function automatic logic [DATA_W-1:0] size_mask(input logic [3:0] bits);
        logic [DATA_W-1:0] m;
        for (int b = 0; b < DATA_W; b++) begin
            m[b] = (4'(b) < bits);
        end
        return m;
    endfunction

endpackage

// File: rtl/qs_range_stack.sv
// LIFO of pending (lo,hi) ranges; push/pop act at the clock edge, top_dat is the newest entry.
// No backpressure: the FSM never pushes into a full stack, and an assertion guards that.
module qs_range_stack
    import quicksort_pkg::*;
#(
    parameter int DEPTH = N_ELEMS
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   push,
    input  range_t push_dat,
    input  logic   pop,
    output range_t top_dat,
    output logic   empty,
    output logic   full
);

    localparam int SP_W = $clog2(DEPTH + 1);

    range_t          entries [DEPTH];
    logic [SP_W-1:0] sp;

    assign empty   = (sp == '0);
    assign full    = (sp == SP_W'(DEPTH));
    assign top_dat = empty ? '0 : entries[sp - SP_W'(1)];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) begin
            entries[sp] <= push_dat;
        end
    end

    assert property (@(posedge clock) disable iff (!reset) !(push && full))
        else $error("qs_range_stack: push while full");

endmodule

// File: rtl/quicksort_accel.sv
// In-place Lomuto quicksort over a 96-byte array, started by start_port and ending with one done_port pulse.
// Slave bus answers one cycle after a hit, only in IDLE; SORT_DESCENDING_EN selects non-increasing order.
module quicksort_accel
    import quicksort_pkg::*;
#(
    parameter int ARRAY_BASE = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start_port,
    output logic                done_port,
    input  logic [1:0]          S_oe_ram,
    input  logic [1:0]          S_we_ram,
    input  logic [2*ADDR_W-1:0] S_addr_ram,
    input  logic [2*DATA_W-1:0] S_Wdata_ram,
    input  logic [7:0]          S_data_ram_size,
    input  logic [2*DATA_W-1:0] M_Rdata_ram,
    input  logic [1:0]          M_DataRdy,
    output logic [2*DATA_W-1:0] Sout_Rdata_ram,
    output logic [1:0]          Sout_DataRdy,
    output logic [1:0]          Mout_oe_ram,
    output logic [1:0]          Mout_we_ram,
    output logic [2*ADDR_W-1:0] Mout_addr_ram,
    output logic [2*DATA_W-1:0] Mout_Wdata_ram,
    output logic [7:0]          Mout_data_ram_size
);

    localparam logic [ADDR_W:0] BASE_A = (ADDR_W + 1)'(ARRAY_BASE);
    localparam logic [ADDR_W:0] END_A  = (ADDR_W + 1)'(ARRAY_BASE + N_ELEMS);

    logic [DATA_W-1:0] mem [N_ELEMS];

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  lo_q, lo_d, hi_q, hi_d;
    logic [IDX_W-1:0]  i_q, i_d, j_q, j_d;
    logic [DATA_W-1:0] pivot_q, pivot_d, tmp_q, tmp_d;
    logic              fin_q, fin_d;
    range_t            pend_q [2];
    range_t            pend_d [2];
    logic [1:0]        pend_vld_q, pend_vld_d;

    logic              fsm_we;
    logic [IDX_W-1:0]  fsm_widx;
    logic [DATA_W-1:0] fsm_wdat;

    logic              stk_push, stk_pop, stk_empty, stk_full;
    range_t            stk_push_dat, stk_top;

    logic              idle;
    logic [1:0]        s_hit;
    logic [IDX_W-1:0]  s_idx  [2];
    logic [DATA_W-1:0] s_wdat [2];
    logic [DATA_W-1:0] s_mask [2];

    logic [DATA_W-1:0] a_i, a_j, a_hi;
    logic              goes_left;
    logic [IDX_W:0]    lsz, rsz;
    range_t            left_r, right_r;
    logic              unused_m;

    assign idle = (state_q == IDLE);

    for (genvar c = 0; c < 2; c++) begin : g_slave
        logic [ADDR_W:0] addr_ext;
        assign addr_ext  = {1'b0, S_addr_ram[c*ADDR_W +: ADDR_W]};
        assign s_hit[c]  = (S_oe_ram[c] | S_we_ram[c]) && (addr_ext >= BASE_A) && (addr_ext < END_A);
        assign s_idx[c]  = IDX_W'(addr_ext - BASE_A);
        assign s_wdat[c] = S_Wdata_ram[c*DATA_W +: DATA_W];
        assign s_mask[c] = size_mask(S_data_ram_size[c*4 +: 4]);
    end

    // Host writes land only in IDLE and FSM writes only outside it, so one write path is ever active.
    // Channel 1 is applied last so it wins a same-address collision.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_ELEMS; k++) begin
                mem[k] <= init_val(k);
            end
        end else if (idle) begin
            for (int c = 0; c < 2; c++) begin
                if (s_hit[c] && S_we_ram[c]) begin
                    mem[s_idx[c]] <= (mem[s_idx[c]] & ~s_mask[c]) | (s_wdat[c] & s_mask[c]);
                end
            end
        end else if (fsm_we) begin
            mem[fsm_widx] <= fsm_wdat;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            Sout_DataRdy   <= '0;
            Sout_Rdata_ram <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                Sout_DataRdy[c] <= idle && s_hit[c];
                Sout_Rdata_ram[c*DATA_W +: DATA_W] <=
                    (idle && s_hit[c] && !S_we_ram[c]) ? mem[s_idx[c]] : '0;
            end
        end
    end

    assign a_i  = mem[i_q];
    assign a_j  = mem[j_q];
    assign a_hi = mem[hi_q];

`ifdef SORT_DESCENDING_EN
    assign goes_left = (a_j > pivot_q);
`else
    assign goes_left = (a_j < pivot_q);
`endif

    // Final pivot slot is i_q; sub-ranges of fewer than two elements need no further work.
    assign lsz     = {1'b0, i_q} - {1'b0, lo_q};
    assign rsz     = {1'b0, hi_q} - {1'b0, i_q};
    assign left_r  = '{lo: lo_q, hi: i_q - IDX_W'(1)};
    assign right_r = '{lo: i_q + IDX_W'(1), hi: hi_q};

    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        i_d          = i_q;
        j_d          = j_q;
        pivot_d      = pivot_q;
        tmp_d        = tmp_q;
        fin_d        = fin_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        stk_push     = 1'b0;
        stk_pop      = 1'b0;
        stk_push_dat = pend_q[0];
        fsm_we       = 1'b0;
        fsm_widx     = i_q;
        fsm_wdat     = a_j;

        unique case (state_q)
            IDLE: begin
                if (start_port) begin
                    pend_d[0]  = '{lo: '0, hi: IDX_W'(N_ELEMS - 1)};
                    pend_vld_d = 2'b01;
                    state_d    = PUSH;
                end
            end
            PUSH: begin
                if (pend_vld_q[0]) begin
                    stk_push      = 1'b1;
                    stk_push_dat  = pend_q[0];
                    pend_vld_d[0] = 1'b0;
                    if (!pend_vld_q[1]) state_d = POP;
                end else if (pend_vld_q[1]) begin
                    stk_push      = 1'b1;
                    stk_push_dat  = pend_q[1];
                    pend_vld_d[1] = 1'b0;
                    state_d       = POP;
                end else begin
                    state_d = POP;
                end
            end
            POP: begin
                if (stk_empty) begin
                    state_d = DONE;
                end else begin
                    stk_pop = 1'b1;
                    lo_d    = stk_top.lo;
                    hi_d    = stk_top.hi;
                    state_d = PART_INIT;
                end
            end
            PART_INIT: begin
                pivot_d = a_hi;
                i_d     = lo_q;
                j_d     = lo_q;
                state_d = PART_SCAN;
            end
            PART_SCAN: begin
                if (j_q == hi_q) begin
                    fin_d   = 1'b0;
                    state_d = PART_FINAL;
                end else if (goes_left) begin
                    fsm_we   = 1'b1;
                    fsm_widx = i_q;
                    fsm_wdat = a_j;
                    tmp_d    = a_i;
                    state_d  = PART_SWAP;
                end else begin
                    j_d = j_q + IDX_W'(1);
                end
            end
            PART_SWAP: begin
                fsm_we   = 1'b1;
                fsm_widx = j_q;
                fsm_wdat = tmp_q;
                i_d      = i_q + IDX_W'(1);
                j_d      = j_q + IDX_W'(1);
                state_d  = PART_SCAN;
            end
            PART_FINAL: begin
                fsm_we = 1'b1;
                if (!fin_q) begin
                    fsm_widx = hi_q;
                    fsm_wdat = a_i;
                    fin_d    = 1'b1;
                end else begin
                    fsm_widx = i_q;
                    fsm_wdat = pivot_q;
                    // Larger range is pushed first so the smaller one is popped and processed next.
                    if (lsz >= rsz) begin
                        pend_d[0]  = left_r;
                        pend_d[1]  = right_r;
                        pend_vld_d = {rsz >= (IDX_W + 1)'(2), lsz >= (IDX_W + 1)'(2)};
                    end else begin
                        pend_d[0]  = right_r;
                        pend_d[1]  = left_r;
                        pend_vld_d = {lsz >= (IDX_W + 1)'(2), rsz >= (IDX_W + 1)'(2)};
                    end
                    state_d = PUSH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lo_q       <= '0;
            hi_q       <= '0;
            i_q        <= '0;
            j_q        <= '0;
            pivot_q    <= '0;
            tmp_q      <= '0;
            fin_q      <= 1'b0;
            pend_q     <= '{default: '0};
            pend_vld_q <= '0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            i_q        <= i_d;
            j_q        <= j_d;
            pivot_q    <= pivot_d;
            tmp_q      <= tmp_d;
            fin_q      <= fin_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    qs_range_stack #(
        .DEPTH (N_ELEMS)
    ) u_stack (
        .clock    (clock),
        .reset    (reset),
        .push     (stk_push),
        .push_dat (stk_push_dat),
        .pop      (stk_pop),
        .top_dat  (stk_top),
        .empty    (stk_empty),
        .full     (stk_full)
    );

    assign done_port          = (state_q == DONE);
    assign Mout_oe_ram        = '0;
    assign Mout_we_ram        = '0;
    assign Mout_addr_ram      = '0;
    assign Mout_Wdata_ram     = '0;
    assign Mout_data_ram_size = '0;

    assign unused_m = ^{M_Rdata_ram, M_DataRdy, stk_full};

endmodule

// File: tb/tb_quicksort_accel.sv
// Directed and randomized checks of quicksort_accel against an array model sorted with queue sort().
module tb_quicksort_accel;

    localparam int N     = 96;
    localparam int BASE  = 32;
    localparam int BOUND = 3 * N * N;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_port;
    logic        done_port;
    logic [1:0]  S_oe_ram, S_we_ram;
    logic [13:0] S_addr_ram;
    logic [15:0] S_Wdata_ram;
    logic [7:0]  S_data_ram_size;
    logic [15:0] M_Rdata_ram;
    logic [1:0]  M_DataRdy;
    logic [15:0] Sout_Rdata_ram;
    logic [1:0]  Sout_DataRdy;
    logic [1:0]  Mout_oe_ram, Mout_we_ram;
    logic [13:0] Mout_addr_ram;
    logic [15:0] Mout_Wdata_ram;
    logic [7:0]  Mout_data_ram_size;

    quicksort_accel dut (
        .clock              (clock),
        .reset              (reset),
        .start_port         (start_port),
        .done_port          (done_port),
        .S_oe_ram           (S_oe_ram),
        .S_we_ram           (S_we_ram),
        .S_addr_ram         (S_addr_ram),
        .S_Wdata_ram        (S_Wdata_ram),
        .S_data_ram_size    (S_data_ram_size),
        .M_Rdata_ram        (M_Rdata_ram),
        .M_DataRdy          (M_DataRdy),
        .Sout_Rdata_ram     (Sout_Rdata_ram),
        .Sout_DataRdy       (Sout_DataRdy),
        .Mout_oe_ram        (Mout_oe_ram),
        .Mout_we_ram        (Mout_we_ram),
        .Mout_addr_ram      (Mout_addr_ram),
        .Mout_Wdata_ram     (Mout_Wdata_ram),
        .Mout_data_ram_size (Mout_data_ram_size)
    );

    always #5 clock = ~clock;

    int         n_tests  = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    logic [7:0] model [N];
    logic [7:0] snap  [N];
    logic [7:0] rd    [2];
    logic [1:0] rdy;

    always @(negedge clock) if (done_port === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at posedge+1, capture registered response one edge later.
    task automatic bus_cycle(input logic [1:0] oe, input logic [1:0] we, input int a0, input int a1,
                             input int d0, input int d1, input int s0, input int s1);
        S_oe_ram        = oe;
        S_we_ram        = we;
        S_addr_ram      = {7'(a1), 7'(a0)};
        S_Wdata_ram     = {8'(d1), 8'(d0)};
        S_data_ram_size = {4'(s1), 4'(s0)};
        @(posedge clock); #1;
        rd[0] = Sout_Rdata_ram[7:0];
        rd[1] = Sout_Rdata_ram[15:8];
        rdy   = Sout_DataRdy;
        S_oe_ram = '0;
        S_we_ram = '0;
    endtask

    task automatic model_write(input int addr, input int d, input int s);
        logic [7:0] m;
        if (addr >= BASE && addr < BASE + N) begin
            m = (s >= 8) ? 8'hFF : 8'((1 << s) - 1);
            model[addr - BASE] = (model[addr - BASE] & ~m) | (8'(d) & m);
        end
    endtask

    task automatic write_all(input string tag);
        int bad = 0;
        for (int k = 0; k < N / 2; k++) begin
            bus_cycle(2'b00, 2'b11, BASE + k, BASE + k + N / 2, model[k], model[k + N / 2], 8, 8);
            if (rdy !== 2'b11) bad++;
        end
        check({tag, "_write_acks_bad"}, bad, 0);
    endtask

    task automatic read_compare(input string tag);
        int bad = 0;
        for (int k = 0; k < N / 2; k++) begin
            bus_cycle(2'b11, 2'b00, BASE + k, BASE + k + N / 2, 0, 0, 8, 8);
            snap[k]         = rd[0];
            snap[k + N / 2] = rd[1];
            if (rdy !== 2'b11) bad++;
        end
        check({tag, "_read_acks_bad"}, bad, 0);
        for (int k = 0; k < N; k++) check($sformatf("%s_a[%0d]", tag, k), snap[k], model[k]);
    endtask

    task automatic model_sort();
        logic [7:0] q[$];
        q = {};
        for (int k = 0; k < N; k++) q.push_back(model[k]);
`ifdef SORT_DESCENDING_EN
        q.rsort();
`else
        q.sort();
`endif
        for (int k = 0; k < N; k++) model[k] = q[k];
    endtask

    task automatic pulse_start();
        start_port = 1'b1;
        @(posedge clock); #1;
        start_port = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base_cnt);
        int cycles = 0;
        while (done_cnt == base_cnt && cycles <= BOUND) begin
            @(posedge clock); #1;
            cycles++;
        end
        check({tag, "_done_seen"}, done_cnt != base_cnt, 1);
        check({tag, "_cycles_in_bound"}, cycles <= BOUND, 1);
        repeat (4) begin @(posedge clock); #1; end
        check({tag, "_done_pulses"}, done_cnt - base_cnt, 1);
    endtask

    task automatic sort_and_check(input string tag);
        int base = done_cnt;
        pulse_start();
        wait_done(tag, base);
        model_sort();
        read_compare(tag);
    endtask

    initial begin
        int base;
        int viol;
        reset           = 1'b0;
        start_port      = 1'b0;
        S_oe_ram        = '0;
        S_we_ram        = '0;
        S_addr_ram      = '0;
        S_Wdata_ram     = '0;
        S_data_ram_size = '0;
        M_Rdata_ram     = '0;
        M_DataRdy       = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_done", done_port, 0);
        check("rst_sout", {Sout_DataRdy, Sout_Rdata_ram}, 0);
        check("rst_mout", {Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size}, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        for (int k = 0; k < N; k++) model[k] = 8'((37 * k + 11) % 256);

        // Reset contents and single-cycle read ack.
        bus_cycle(2'b01, 2'b00, 32, 0, 0, 0, 8, 8);
        check("rd32_data", rd[0], 11);
        check("rd32_rdy", rdy, 2'b01);
        bus_cycle(2'b10, 2'b00, 0, 127, 0, 0, 8, 8);
        check("rd127_data", rd[1], 198);
        check("rd127_rdy", rdy, 2'b10);
        bus_cycle(2'b00, 2'b00, 0, 0, 0, 0, 8, 8);
        check("rdy_drops", rdy, 2'b00);
        read_compare("init");

        // Sort of the reset pattern.
        sort_and_check("sort_init");
`ifdef SORT_DESCENDING_EN
        check("sorted_first", snap[0], 254);
        check("sorted_last", snap[N-1], 1);
`else
        check("sorted_first", snap[0], 1);
        check("sorted_last", snap[N-1], 254);
`endif
        viol = 0;
        for (int k = 0; k < N - 1; k++) begin
`ifdef SORT_DESCENDING_EN
            if (snap[k] < snap[k+1]) viol++;
`else
            if (snap[k] > snap[k+1]) viol++;
`endif
        end
        check("order_violations", viol, 0);

        // All duplicates.
        for (int k = 0; k < N; k++) model[k] = 8'hFF;
        write_all("dup");
        sort_and_check("sort_dup");

        // Strictly descending input.
        for (int k = 0; k < N; k++) model[k] = 8'(N - 1 - k);
        write_all("desc");
        sort_and_check("sort_desc");

        // Address decode edges and write corner cases.
        bus_cycle(2'b01, 2'b00, 10, 0, 0, 0, 8, 8);
        check("miss10_data", rd[0], 0);
        check("miss10_rdy", rdy, 2'b00);
        bus_cycle(2'b11, 2'b00, 31, 0, 0, 0, 8, 8);
        check("miss31_0_lanes", {rd[1], rd[0]}, 0);
        check("miss31_0_rdy", rdy, 2'b00);
        bus_cycle(2'b00, 2'b01, 40, 0, 8'hA5, 0, 4, 8);
        model_write(40, 8'hA5, 4);
        check("mask_wr_rdy", rdy, 2'b01);
        bus_cycle(2'b00, 2'b11, 41, 41, 8'h11, 8'h22, 8, 8);
        model_write(41, 8'h11, 8);
        model_write(41, 8'h22, 8);
        bus_cycle(2'b01, 2'b01, 42, 0, 8'h5A, 0, 8, 8);
        model_write(42, 8'h5A, 8);
        check("oe_we_rdy", rdy, 2'b01);
        check("oe_we_lane", rd[0], 0);
        read_compare("wr_corner");

        // Busy behaviour: reads and writes refused, restart ignored.
        for (int k = 0; k < N; k++) model[k] = 8'($urandom_range(0, 255));
        write_all("busy");
        base = done_cnt;
        pulse_start();
        bus_cycle(2'b01, 2'b00, 40, 0, 0, 0, 8, 8);
        check("busy_rd_rdy", rdy, 2'b00);
        check("busy_rd_data", rd[0], 0);
        bus_cycle(2'b00, 2'b10, 0, 41, 0, 8'h00, 8, 8);
        check("busy_wr_rdy", rdy, 2'b00);
        pulse_start();
        wait_done("busy", base);
        model_sort();
        read_compare("busy");

        // Randomized arrays, including heavy duplicates.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N; k++)
                model[k] = 8'((r == 1) ? $urandom_range(0, 7) : $urandom_range(0, 255));
            write_all($sformatf("rand%0d", r));
            sort_and_check($sformatf("rand%0d", r));
        end

        // Reset during a sort of presorted data (long enough to still be running).
        base = done_cnt;
        pulse_start();
        repeat (100) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (50) @(posedge clock);
        #1;
        check("abort_no_done", done_cnt - base, 0);
        for (int k = 0; k < N; k++) model[k] = 8'((37 * k + 11) % 256);
        bus_cycle(2'b01, 2'b00, 32, 0, 0, 0, 8, 8);
        check("abort_rd32", rd[0], 11);
        read_compare("abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
